// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot/periodic modes, pause/resume and
// a registered terminal-count strobe.
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc_pulse
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;
   logic             w_go;

   // stop outranks start, so a combined request never resumes
   assign w_go = start & ~stop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (load) begin
            r_reload <= load_value;
            r_count  <= load_value;
            r_state  <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_go && r_count != '0) r_state <= RUN;
               end
               RUN: begin
                  if (stop) begin
                     r_state <= PAUSE;
                  end else if (r_count > ONE) begin
                     r_count <= r_count - ONE;
                  end else if (r_count == ONE) begin
                     r_tc <= 1'b1;
                     if (auto_reload) begin
                        r_count <= r_reload;
                     end else begin
                        r_count <= '0;
                        r_state <= DONE;
                     end
                  end else begin
                     // defensive: a zero count in RUN ends quietly, no strobe
                     r_state <= DONE;
                  end
               end
               PAUSE: begin
                  if (w_go) r_state <= RUN;
               end
               DONE: begin
                  if (w_go) begin
                     r_count <= r_reload;
                     r_state <= (r_reload != '0) ? RUN : IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign count    = r_count;
   assign busy     = (r_state == RUN);
   assign done     = (r_state == DONE);
   assign tc_pulse = r_tc;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed scoreboard bench for down_counter_timer (WIDTH=4).
module tb_down_counter_timer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         load;
   logic [W-1:0] load_value;
   logic         start;
   logic         stop;
   logic         auto_reload;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         tc_pulse;

   typedef struct {
      string        tag;
      logic [W-1:0] cnt;
      logic         busy;
      logic         done;
      logic         tc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .start(start), .stop(stop), .auto_reload(auto_reload),
      .count(count), .busy(busy), .done(done), .tc_pulse(tc_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge
   task automatic step(input string tag, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic sp, input logic ar,
                       input logic [W-1:0] ecnt, input logic eb, input logic ed, input logic et);
      exp_t e;
      load = ld; load_value = lv; start = st; stop = sp; auto_reload = ar;
      e.tag = tag; e.cnt = ecnt; e.busy = eb; e.done = ed; e.tc = et;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_count"}, count, e.cnt);
         chk({e.tag, "_busy"},  busy,  e.busy);
         chk({e.tag, "_done"},  done,  e.done);
         chk({e.tag, "_tc"},    tc_pulse, e.tc);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; load = 0; load_value = '0; start = 0; stop = 0; auto_reload = 0;
      #12;
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tc", tc_pulse, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // one-shot from 5
      step("os_load",  1, 5, 0, 0, 0, 5, 0, 0, 0);
      step("os_start", 0, 0, 1, 0, 0, 5, 1, 0, 0);
      step("os_4",     0, 0, 0, 0, 0, 4, 1, 0, 0);
      step("os_3",     0, 0, 0, 0, 0, 3, 1, 0, 0);
      step("os_2",     0, 0, 0, 0, 0, 2, 1, 0, 0);
      step("os_1",     0, 0, 0, 0, 0, 1, 1, 0, 0);
      step("os_0",     0, 0, 0, 0, 0, 0, 0, 1, 1);
      step("os_hold",  0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("os_stop_done", 0, 0, 0, 1, 0, 0, 0, 1, 0);
      // restart from DONE reloads 5
      step("done_start", 0, 0, 1, 0, 0, 5, 1, 0, 0);
      step("done_run4",  0, 0, 0, 0, 0, 4, 1, 0, 0);

      // pause / resume from 9
      step("pz_load",  1, 9, 0, 0, 0, 9, 0, 0, 0);
      step("pz_start", 0, 0, 1, 0, 0, 9, 1, 0, 0);
      step("pz_8",     0, 0, 0, 0, 0, 8, 1, 0, 0);
      step("pz_7",     0, 0, 0, 0, 0, 7, 1, 0, 0);
      step("pz_6",     0, 0, 0, 0, 0, 6, 1, 0, 0);
      step("pz_stop",  0, 0, 0, 1, 0, 6, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("pz_hold", 0, 0, 0, 0, 0, 6, 0, 0, 0);
      step("pz_both",  0, 0, 1, 1, 0, 6, 0, 0, 0);
      step("pz_resume",0, 0, 1, 0, 0, 6, 1, 0, 0);
      step("pz_5",     0, 0, 0, 0, 0, 5, 1, 0, 0);
      step("pz_4",     0, 0, 0, 0, 0, 4, 1, 0, 0);
      // load beats start+stop mid-run
      step("ld_prio",  1, 10, 1, 1, 0, 10, 0, 0, 0);
      step("ld_idle",  0, 0, 0, 0, 0, 10, 0, 0, 0);
      step("idle_stop",0, 0, 0, 1, 0, 10, 0, 0, 0);
      step("idle_both",0, 0, 1, 1, 0, 10, 0, 0, 0);
      step("run_both", 0, 0, 1, 0, 0, 10, 1, 0, 0);
      step("run_sb",   0, 0, 1, 1, 0, 10, 0, 0, 0);

      // periodic mode, reload 3
      step("ar_load",  1, 3, 0, 0, 1, 3, 0, 0, 0);
      step("ar_start", 0, 0, 1, 0, 1, 3, 1, 0, 0);
      for (int p = 0; p < 3; p++) begin
         step("ar_2", 0, 0, 0, 0, 1, 2, 1, 0, 0);
         step("ar_1", 0, 0, 0, 0, 1, 1, 1, 0, 0);
         step("ar_3", 0, 0, 0, 0, 1, 3, 1, 0, 1);
      end
      // switch to one-shot mid-period
      step("ar_off2",  0, 0, 0, 0, 0, 2, 1, 0, 0);
      step("ar_off1",  0, 0, 0, 0, 0, 1, 1, 0, 0);
      step("ar_off0",  0, 0, 0, 0, 0, 0, 0, 1, 1);

      // periodic with reload 1
      step("r1_load",  1, 1, 0, 0, 1, 1, 0, 0, 0);
      step("r1_start", 0, 0, 1, 0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step("r1_tc", 0, 0, 0, 0, 1, 1, 1, 0, 1);
      step("r1_end",   0, 0, 0, 0, 0, 0, 0, 1, 1);

      // zero load: start ignored
      step("z_load",   1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("z_start",  0, 0, 1, 0, 0, 0, 0, 0, 0);
      step("z_start2", 0, 0, 1, 0, 1, 0, 0, 0, 0);

      // async reset mid-run at count 7
      step("rs_load",  1, 15, 0, 0, 0, 15, 0, 0, 0);
      step("rs_start", 0, 0, 1, 0, 0, 15, 1, 0, 0);
      for (int v = 14; v >= 7; v--) step("rs_run", 0, 0, 0, 0, 0, W'(v), 1, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_tc", tc_pulse, 0);
      #3 reset = 1'b0;
      step("rs_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("rs_start0",0, 0, 1, 0, 0, 0, 0, 0, 0);
      // reload register cleared by reset: DONE path cannot be reached without a load
      step("rs_load6", 1, 6, 0, 0, 0, 6, 0, 0, 0);
      step("rs_go6",   0, 0, 1, 0, 0, 6, 1, 0, 0);
      step("rs_5",     0, 0, 0, 0, 0, 5, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, counter and load-value width in bits (legal range 2..16).
REQ-002 Port clk SHALL be: clk  input  1  rising-edge clock for all state.
REQ-003 Port reset SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port load SHALL be: load  input  1  capture load_value into reload register and counter.
REQ-005 Port load_value SHALL be: load_value  input  WIDTH  start/reload value.
REQ-006 Port start SHALL be: start  input  1  begin or resume counting.
REQ-007 Port stop SHALL be: stop  input  1  pause counting.
REQ-008 Port auto_reload SHALL be: auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled every cycle.
REQ-009 Port count SHALL be: count  output  WIDTH  current counter value, registered.
REQ-010 Port busy SHALL be: busy  output  1  high while in RUN.
REQ-011 Port done SHALL be: done  output  1  high while in DONE.
REQ-012 Port tc_pulse SHALL be: tc_pulse  output  1  registered one-cycle terminal-count strobe.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE; busy = (state==RUN), done = (state==DONE).
REQ-014 A reload register of WIDTH bits SHALL hold the last captured load_value.
REQ-015 Control priority SHALL be load > stop > start, all sampled on the rising clk edge.
REQ-016 load=1 in any state SHALL set reload register and count to load_value and move to IDLE next cycle; tc_pulse SHALL be 0 that cycle.
REQ-017 start in IDLE SHALL move to RUN if count != 0; with count == 0 it SHALL have no effect.
REQ-018 start in PAUSE SHALL move to RUN with count unchanged.
REQ-019 start in DONE SHALL set count to the reload register and move to RUN if reload != 0, else to IDLE.
REQ-020 In RUN with count > 1, count SHALL decrement by exactly 1 per cycle.
REQ-021 In RUN with count == 1 and auto_reload=0, next cycle SHALL give count=0, state DONE, tc_pulse=1.
REQ-022 In RUN with count == 1 and auto_reload=1, next cycle SHALL give count=reload register, state RUN, tc_pulse=1; period is therefore exactly reload-value cycles.
REQ-023 Reload value 1 with auto_reload=1 SHALL hold count at 1 with tc_pulse high every cycle.
REQ-024 stop in RUN SHALL move to PAUSE with count frozen; stop in other states SHALL have no effect.
REQ-025 start and stop asserted together SHALL act as stop (RUN->PAUSE, PAUSE stays).
REQ-026 tc_pulse SHALL be high only in the cycle following a count==1 decrement step in RUN, never otherwise.
REQ-027 Count SHALL never wrap below 0; arithmetic is unsigned WIDTH-bit with no underflow path.
REQ-028 In IDLE, PAUSE and DONE, count SHALL hold unless load or DONE-start applies.

Reset
REQ-029 reset=1 SHALL immediately, independent of clk, force count=0, reload register=0, state IDLE, busy=0, done=0, tc_pulse=0.
REQ-030 Reset asserted mid-RUN SHALL abort the count with no tc_pulse; after release the block SHALL wait in IDLE for load.

Verification
REQ-031 WIDTH=4: reset, load 5, start -> count 5,4,3,2,1,0 on successive cycles; tc_pulse=1 only with count=0; done=1, busy=0 after.
REQ-032 load 3, auto_reload=1, start -> count 3,2,1,3,2,1,3...; tc_pulse high each time count shows 3 after a reload (every 3 cycles); done never high.
REQ-033 Running from 9, stop at count 6, hold 4 cycles -> count stays 6, state PAUSE; start -> 5,4,... continues.
REQ-034 load 0, start -> remains IDLE, count 0, no tc_pulse; DONE with reload 0, start -> IDLE.
REQ-035 load 15, start, assert reset asynchronously at count 7 -> count 0, busy 0, tc_pulse 0 before next clk edge.
REQ-036 In RUN at count 4, load=1 (value 10) with start=1 and stop=1 same cycle -> count 10, state IDLE, no tc_pulse.
